// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard; zero-latency reads, writes/issues update on the clk edge; x0 hardwired to zero.
// Issue backpressure: iss_ready drops while the destination is busy unless a same-cycle write frees it; REGFILE_BYPASS_EN enables write-through reads.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  we,
   input  logic [AW-1:0]         rd_addr,
   input  logic [XLEN-1:0]       wd,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   output logic                  iss_ready,
   output logic [NREGS-1:0]      busy_vec
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr_en;
   logic             iss_fire;

   assign wr_en     = we && (rd_addr != '0);
   assign iss_ready = !busy[iss_rd] || (wr_en && (rd_addr == iss_rd));
   assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
   assign busy_vec  = busy;

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      end else if (wr_en) begin
         regs[rd_addr] <= wd;
      end
   end

   // Clear first, then set, so an issue on the same edge as its write leaves the register busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         if (wr_en)    busy[rd_addr] <= 1'b0;
         if (iss_fire) busy[iss_rd]  <= 1'b1;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_read
      logic [AW-1:0] addr;
      assign addr = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic byp;
      // Gated by rst so the outputs stay zero while reset is held.
      assign byp = wr_en && (addr == rd_addr) && rst;
      assign rs_data[i*XLEN +: XLEN] = byp ? wd : regs[addr];
      assign rs_busy[i]              = busy[addr] && !byp;
`else
      assign rs_data[i*XLEN +: XLEN] = regs[addr];
      assign rs_busy[i]              = busy[addr];
`endif
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard (2 read ports, 32x32); expectations follow the REGFILE_BYPASS_EN build setting.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rs_addr;
   logic [63:0] rs_data;
   logic [1:0]  rs_busy;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] wd;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [31:0] busy_vec;

   int checks = 0;
   int errors = 0;

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
      .we(we), .rd_addr(rd_addr), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ready(iss_ready), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [1:0]  e_busy;
      logic        e_rdy;
      logic [31:0] e_bv;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic [4:0] rd, input logic [31:0] d,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic er, input logic [31:0] ebv);
      vec_t v;
      v.we = w; v.rd = rd; v.wd = d; v.iv = iv; v.ird = ird; v.a0 = a0; v.a1 = a1;
      v.e_d0 = e0; v.e_d1 = e1; v.e_busy = eb; v.e_rdy = er; v.e_bv = ebv;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      we = v.we; rd_addr = v.rd; wd = v.wd; iss_valid = v.iv; iss_rd = v.ird;
      rs_addr = {v.a1, v.a0};
   endtask

   localparam logic [31:0] B4 = 32'h1 << 4;
   localparam logic [31:0] B7 = 32'h1 << 7;
   localparam logic [31:0] B9 = 32'h1 << 9;

   initial begin
      // we rd wd iv ird a0 a1 | d0 d1 busy rdy busy_vec   (outputs before the edge)
      add(0, 0, 0,            0, 0, 0, 5,  0, 0, 2'b00, 1, 0);
      add(1, 5, 32'hDEADBEEF, 0, 0, 5, 5,  BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, 2'b00, 1, 0);
      add(0, 0, 0,            0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0);
      add(1, 0, 32'h1234,     0, 0, 0, 0,  0, 0, 2'b00, 1, 0);
      add(0, 0, 0,            0, 0, 0, 5,  0, 32'hDEADBEEF, 2'b00, 1, 0);
      add(0, 0, 0,            1, 7, 7, 7,  0, 0, 2'b00, 1, 0);
      add(0, 0, 0,            1, 7, 7, 7,  0, 0, 2'b11, 0, B7);
      add(1, 7, 32'h55,       0, 7, 7, 0,  BYP ? 32'h55 : 0, 0, BYP ? 2'b00 : 2'b01, 1, B7);
      add(0, 0, 0,            0, 7, 7, 0,  32'h55, 0, 2'b00, 1, 0);
      add(0, 0, 0,            1, 9, 9, 7,  0, 32'h55, 2'b00, 1, 0);
      add(1, 9, 32'hA5A5A5A5, 1, 9, 9, 7,  BYP ? 32'hA5A5A5A5 : 0, 32'h55, BYP ? 2'b00 : 2'b01, 1, B9);
      add(0, 0, 0,            0, 0, 9, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11, 1, B9);
      add(1, 3, 32'h11,       0, 0, 0, 0,  0, 0, 2'b00, 1, B9);
      add(1, 3, 32'h77,       0, 0, 3, 3,  BYP ? 32'h77 : 32'h11, BYP ? 32'h77 : 32'h11, 2'b00, 1, B9);
      add(0, 0, 0,            0, 0, 3, 3,  32'h77, 32'h77, 2'b00, 1, B9);
      add(1, 0, 32'h9999,     1, 0, 0, 0,  0, 0, 2'b00, 1, B9);
      add(0, 0, 0,            0, 9, 0, 9,  0, 32'hA5A5A5A5, 2'b10, 0, B9);
      add(1, 12, 32'hCAFE,    1, 4, 4, 12, 0, BYP ? 32'hCAFE : 0, 2'b00, 1, B9);
      add(0, 0, 0,            0, 4, 4, 12, 0, 32'hCAFE, 2'b01, 0, B4 | B9);
      add(1, 4, 32'hFF,       1, 4, 4, 4,  BYP ? 32'hFF : 0, BYP ? 32'hFF : 0, BYP ? 2'b00 : 2'b11, 1, B4 | B9);
      add(0, 0, 0,            0, 0, 4, 12, 32'hFF, 32'hCAFE, 2'b01, 1, B4 | B9);

      // Reset held: every register reads zero on both ports.
      rst = 1'b0; we = 0; rd_addr = 0; wd = 0; iss_valid = 0; iss_rd = 0; rs_addr = 0;
      repeat (2) @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         rs_addr = {a[4:0], a[4:0]};
         #1;
         chk($sformatf("reset_rd_x%0d", a), rs_data[31:0] | rs_data[63:32], 32'h0);
      end
      chk("reset_busy_vec", busy_vec, 32'h0);
      chk("reset_iss_ready", {31'h0, iss_ready}, 32'h1);
      chk("reset_rs_busy", {30'h0, rs_busy}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_d0", i), rs_data[31:0], vecs[i].e_d0);
         chk($sformatf("v%0d_d1", i), rs_data[63:32], vecs[i].e_d1);
         chk($sformatf("v%0d_busy", i), {30'h0, rs_busy}, {30'h0, vecs[i].e_busy});
         chk($sformatf("v%0d_rdy", i), {31'h0, iss_ready}, {31'h0, vecs[i].e_rdy});
         chk($sformatf("v%0d_bv", i), busy_vec, vecs[i].e_bv);
      end

      // Asynchronous reset mid-cycle: x4=0xFF and busy[4]=1 before; outputs clear with no clock edge.
      @(negedge clk);
      we = 0; iss_valid = 0; iss_rd = 4; rs_addr = {5'd4, 5'd4};
      #1;
      chk("pre_arst_x4", rs_data[31:0], 32'hFF);
      chk("pre_arst_bv", busy_vec, B4 | B9);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_x4", rs_data[31:0] | rs_data[63:32], 32'h0);
      chk("arst_bv", busy_vec, 32'h0);
      chk("arst_rs_busy", {30'h0, rs_busy}, 32'h0);
      chk("arst_rdy", {31'h0, iss_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rs_addr = {5'd12, 5'd9};
      #1;
      chk("post_arst_x9_x12", rs_data[31:0] | rs_data[63:32], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
